// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the fetch and memory stages onto one split-transaction SRAM port,
// tracking request ownership in an in-order ID queue for response routing.
module cpu_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned PRIO_DATA       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t                     state, state_d;
  logic [CW-1:0]              count;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [MAX_OUTSTANDING-1:0] ids;
  logic                       last_served_data;
  logic                       err_underflow;
  logic                       sel_valid, sel_data;
  logic                       full, push, pop, head;

  // Sticky debug flag; only observed from simulation.
  logic err_underflow_unused;
  assign err_underflow_unused = err_underflow;

  // Grant selection and next state; IDLE decides combinationally for zero latency.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = 1'b0;
    state_d   = IDLE;
    case (state)
      GNT_I: sel_valid = inst_req;
      GNT_D: begin
        sel_valid = data_req;
        sel_data  = 1'b1;
      end
      default: begin
        if (data_req && (!inst_req || PRIO_DATA != 0 || !last_served_data)) begin
          sel_valid = 1'b1;
          sel_data  = 1'b1;
        end else begin
          sel_valid = inst_req;
        end
      end
    endcase
    full    = (count == CW'(MAX_OUTSTANDING));
    mem_req = sel_valid && !full;
    push    = mem_req && mem_addr_ok;
    // A grant is held only once it has been presented, or while already held.
    if (sel_valid && !push && (state != IDLE || mem_req))
      state_d = sel_data ? GNT_D : GNT_I;
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel_valid && sel_data) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (sel_valid) begin
      mem_size  = 2'd2;
      mem_addr  = inst_addr;
    end
  end

  assign inst_addr_ok = push && !sel_data;
  assign data_addr_ok = push && sel_data;

  assign pop          = mem_data_ok && (count != '0);
  assign head         = ids[rd_ptr];
  assign inst_data_ok = pop && !head;
  assign data_data_ok = pop && head;
  assign inst_rdata   = (pop && !head) ? mem_rdata : '0;
  assign data_rdata   = (pop && head) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      ids              <= '0;
      last_served_data <= 1'b0;
      err_underflow    <= 1'b0;
    end else begin
      state <= state_d;
      if (push) begin
        ids[wr_ptr]      <= sel_data;
        wr_ptr           <= wr_ptr + PW'(1);
        last_served_data <= sel_data;
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (mem_data_ok && count == '0)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_cpu_mem_arbiter;

  localparam int MAX  = 2;
  localparam int PRIO = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  // Reference model state: owner of held grant (-1 none, 0 inst, 1 data),
  // queue of outstanding requester IDs, last side served, sticky underflow.
  int mq[$];
  int m_owner   = -1;
  int m_last    = 0;
  bit m_err     = 1'b0;
  bit m_inst_acc = 1'b0;
  bit m_data_acc = 1'b0;
  bit started   = 1'b0;

  cpu_mem_arbiter #(.MAX_OUTSTANDING(MAX), .PRIO_DATA(PRIO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model compare and advance, once per cycle on the inactive edge.
  always @(negedge clk) begin
    int pick;
    int head;
    bit preq, full, mreq, acc;
    if (started) begin
      if (m_owner < 0) begin
        if (data_req && (!inst_req || PRIO != 0 || m_last == 0)) pick = 1;
        else if (inst_req) pick = 0;
        else pick = -1;
      end else begin
        pick = m_owner;
      end
      preq = (pick == 1) ? data_req : (pick == 0) ? inst_req : 1'b0;
      full = (mq.size() == MAX);
      mreq = preq && !full;
      acc  = mreq && mem_addr_ok;
      head = (mem_data_ok && mq.size() > 0) ? mq[0] : -1;

      chk("mem_req", 32'(mem_req), 32'(mreq));
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(acc && pick == 0));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(acc && pick == 1));
      if (mreq) begin
        chk("mem_addr", mem_addr, (pick == 1) ? data_addr : inst_addr);
        chk("mem_wr", 32'(mem_wr), (pick == 1) ? 32'(data_wr) : 32'd0);
        chk("mem_size", 32'(mem_size), (pick == 1) ? 32'(data_size) : 32'd2);
        chk("mem_wstrb", 32'(mem_wstrb), (pick == 1) ? 32'(data_wstrb) : 32'd0);
        chk("mem_wdata", mem_wdata, (pick == 1) ? data_wdata : 32'd0);
      end
      chk("inst_data_ok", 32'(inst_data_ok), 32'(head == 0));
      chk("data_data_ok", 32'(data_data_ok), 32'(head == 1));
      chk("inst_rdata", inst_rdata, (head == 0) ? mem_rdata : 32'd0);
      chk("data_rdata", data_rdata, (head == 1) ? mem_rdata : 32'd0);
      chk("err_underflow", 32'(dut.err_underflow), 32'(m_err));

      m_inst_acc = acc && pick == 0;
      m_data_acc = acc && pick == 1;
      if (!reset) begin
        if (head >= 0) void'(mq.pop_front());
        else if (mem_data_ok) m_err = 1'b1;
        if (acc) begin
          mq.push_back(pick);
          m_last = pick;
        end
        m_owner = (preq && !acc && (m_owner >= 0 || mreq)) ? pick : -1;
      end
    end
    if (reset) begin
      mq.delete();
      m_owner = -1;
      m_last  = 0;
      m_err   = 1'b0;
      started = 1'b1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = 2'd0; data_wstrb = 4'h0;
    data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  initial begin
    reset = 1;
    quiet();
    repeat (2) next_cycle();
    reset = 0;
    @(negedge clk);
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst count", 32'(dut.count), 0);

    // Single fetch, immediate accept, later response.
    next_cycle();
    inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    @(negedge clk);
    chk("t1 inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("t1 mem_addr", mem_addr, 32'h1c000000);
    chk("t1 mem_size", 32'(mem_size), 2);
    next_cycle();
    quiet(); mem_data_ok = 1; mem_rdata = 32'h02c00421;
    @(negedge clk);
    chk("t1 inst_data_ok", 32'(inst_data_ok), 1);
    chk("t1 inst_rdata", inst_rdata, 32'h02c00421);
    chk("t1 data_data_ok", 32'(data_data_ok), 0);

    // Simultaneous requests: data wins, inst next cycle, responses in order.
    next_cycle();
    quiet();
    inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 32'h1c008000; data_wdata = 32'h12345678; mem_addr_ok = 1;
    @(negedge clk);
    chk("t2 data_addr_ok", 32'(data_addr_ok), 1);
    chk("t2 inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("t2 mem_wr", 32'(mem_wr), 1);
    chk("t2 mem_wdata", mem_wdata, 32'h12345678);
    next_cycle();
    data_req = 0;
    @(negedge clk);
    chk("t2 inst second", 32'(inst_addr_ok), 1);
    chk("t2 mem_wr inst", 32'(mem_wr), 0);
    next_cycle();
    quiet(); mem_data_ok = 1; mem_rdata = 32'haaaa0001;
    @(negedge clk);
    chk("t2 resp1 data", 32'(data_data_ok), 1);
    chk("t2 resp1 rdata", data_rdata, 32'haaaa0001);
    next_cycle();
    mem_rdata = 32'hbbbb0002;
    @(negedge clk);
    chk("t2 resp2 inst", 32'(inst_data_ok), 1);
    chk("t2 resp2 rdata", inst_rdata, 32'hbbbb0002);

    // Held data grant ignores inst; then queue fills and stalls.
    next_cycle();
    quiet();
    data_req = 1; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 32'h1c008000; data_wdata = 32'h12345678;
    @(negedge clk);
    chk("t3 data_addr_ok wait", 32'(data_addr_ok), 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      inst_req = 1; inst_addr = 32'h1c000010;
      @(negedge clk);
      chk("t3 held mem_addr", mem_addr, 32'h1c008000);
      chk("t3 inst blocked", 32'(inst_addr_ok), 0);
    end
    next_cycle();
    mem_addr_ok = 1;
    @(negedge clk);
    chk("t3 data accept", 32'(data_addr_ok), 1);
    chk("t3 inst still", 32'(inst_addr_ok), 0);
    next_cycle();
    data_req = 0;
    @(negedge clk);
    chk("t3 inst accept", 32'(inst_addr_ok), 1);
    next_cycle();
    inst_addr = 32'h1c000014;
    @(negedge clk);
    chk("t4 full mem_req", 32'(mem_req), 0);
    chk("t4 full addr_ok", 32'(inst_addr_ok), 0);
    next_cycle();
    mem_data_ok = 1;
    @(negedge clk);
    chk("t4 pop at full", 32'(data_data_ok), 1);
    chk("t4 still stalled", 32'(mem_req), 0);
    next_cycle();
    mem_data_ok = 0;
    @(negedge clk);
    chk("t4 freed accept", 32'(inst_addr_ok), 1);
    next_cycle();
    inst_req = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("t4 drain", 32'(inst_data_ok), 1);

    // Back-to-back push+pop with one entry outstanding, alternating owners.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      quiet();
      inst_req = (i % 2 == 0); inst_addr = 32'h1c000100 + 32'(i);
      data_req = (i % 2 == 1); data_addr = 32'h1c008100 + 32'(i);
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'(i);
      @(negedge clk);
      chk("t5 head inst", 32'(inst_data_ok), 32'(i == 0 || (i - 1) % 2 == 0));
      chk("t5 head data", 32'(data_data_ok), 32'(i != 0 && (i - 1) % 2 == 1));
      chk("t5 accept", 32'(inst_addr_ok | data_addr_ok), 1);
      chk("t5 count", 32'(dut.count), 1);
    end
    next_cycle();
    quiet(); mem_data_ok = 1;
    @(negedge clk);
    chk("t5 last data", 32'(data_data_ok), 1);

    // Reset while data holds grant with one outstanding; stray response after.
    next_cycle();
    quiet(); inst_req = 1; mem_addr_ok = 1;
    @(negedge clk);
    chk("t6 inst accept", 32'(inst_addr_ok), 1);
    next_cycle();
    quiet(); data_req = 1; data_addr = 32'h1c008040;
    @(negedge clk);
    chk("t6 gnt_d mem_req", 32'(mem_req), 1);
    next_cycle();
    reset = 1;
    next_cycle();
    reset = 0; quiet();
    @(negedge clk);
    chk("t6 rst count", 32'(dut.count), 0);
    chk("t6 rst mem_req", 32'(mem_req), 0);
    next_cycle();
    mem_data_ok = 1; mem_rdata = 32'hdeadbeef;
    @(negedge clk);
    chk("t6 stray no ok", 32'(inst_data_ok | data_data_ok), 0);
    next_cycle();
    quiet();
    @(negedge clk);
    chk("t6 underflow", 32'(dut.err_underflow), 1);
    next_cycle();
    inst_req = 1; mem_addr_ok = 1;
    @(negedge clk);
    chk("t6 idle after rst", 32'(inst_addr_ok), 1);
    next_cycle();
    quiet(); mem_data_ok = 1;

    // Randomized traffic; requesters hold fields until their addr_ok.
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      reset = ($urandom_range(0, 299) == 0);
      if (!(inst_req && !m_inst_acc && $urandom_range(0, 15) != 0)) begin
        inst_req  = ($urandom_range(0, 1) == 1);
        inst_addr = $urandom;
      end
      if (!(data_req && !m_data_acc && $urandom_range(0, 15) != 0)) begin
        data_req   = ($urandom_range(0, 1) == 1);
        data_wr    = ($urandom_range(0, 1) == 1);
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = (mq.size() > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 99) == 0);
      mem_rdata   = $urandom;
    end
    next_cycle();
    quiet();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one SRAM-like memory port between the fetch stage (instruction requester) and the memory stage (data requester).
- Uses the req/addr_ok/data_ok split-transaction protocol on all three sides.
- Grants one address phase per cycle and holds the grant until addr_ok.
- Records the owner of each accepted request in an in-order ID queue, and routes each data_ok/rdata back to the correct requester.
- Sits between the pipeline stages and the memory bridge, replacing direct inst/data SRAM ports.

Parameters:
- MAX_OUTSTANDING, 2, max accepted requests awaiting data_ok (power of 2, >=2)
- PRIO_DATA, 1, 1 = data wins simultaneous new requests; 0 = round-robin

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_req  in  1  fetch address-phase request (read only)
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch address accepted this cycle
- inst_data_ok  out  1  fetch read data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  data address-phase request
- data_wr  in  1  1 = write
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data response (read data or write ack)
- data_rdata  out  32  data read data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write
- mem_size  out  2  downstream size
- mem_wstrb  out  4  downstream strobes
- mem_addr  out  32  downstream address
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream address accepted
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  32  downstream read data

Behaviour:
- Reset values:
  - State IDLE; queue empty (count = 0, pointers = 0).
  - All *_ok outputs 0; mem_req 0; other outputs 0.
- States:
  - IDLE: no grant held.
  - GNT_I: inst owns address phase.
  - GNT_D: data owns address phase.
- Request selection:
  - mem_* is a combinational mux of the granted requester's fields.
  - In IDLE the selection is made combinationally in the same cycle, so a request can be accepted in its first cycle (zero added address latency).
  - In IDLE, when both requesters are active:
    - PRIO_DATA = 1: data wins.
    - PRIO_DATA = 0: the side not served last wins. last_served resets to inst, so data wins the first tie.
- mem_req = selected req && !queue_full.
  - When the queue is full, nothing is presented downstream and no *_addr_ok is driven.
- Address handshake and grant holding:
  - On mem_req && mem_addr_ok, drive the winner's *_addr_ok = 1 in the same cycle, push its ID (0 = inst, 1 = data) into the queue, and return to or stay in IDLE.
  - If mem_req && !mem_addr_ok, move to GNT_I/GNT_D and hold that owner until mem_addr_ok.
  - While the grant is held, the other requester is ignored.
  - Requesters keep their fields stable until addr_ok, per protocol.
  - If the owner drops its req while a grant is held (protocol violation), return to IDLE with no push.
- Response routing:
  - On mem_data_ok, pop the queue head.
  - Head = 0: inst_data_ok = 1 and inst_rdata = mem_rdata.
  - Head = 1: data_data_ok = 1 and data_rdata = mem_rdata.
  - The non-selected rdata output is 0.
  - data_ok is combinational from mem_data_ok, so response latency is 0 extra cycles.
- Queue:
  - Circular buffer of depth MAX_OUTSTANDING with wrapping read/write pointers.
  - Count width = clog2(MAX_OUTSTANDING) + 1.
  - Push and pop in the same cycle leave count unchanged; this is legal even when full, since a pop at full does not enable a push that same cycle (full is evaluated on the registered count).
  - mem_data_ok with the queue empty: ignore it (no *_data_ok) and set the sticky debug flag err_underflow (internal, reset 0).
- Reset mid-transaction: queue and state clear immediately. Responses still in flight downstream are the bridge's responsibility; the bridge is reset together with this block.
- The inst side never issues writes: the inst path forces wr = 0, size = 2, wstrb = 0, wdata = 0.

Test Plan:
- inst_req alone, addr 0x1c000000, mem_addr_ok = 1 immediately → inst_addr_ok = 1 same cycle. A later mem_data_ok with rdata 0x02c00421 → inst_data_ok = 1, inst_rdata = 0x02c00421, data_data_ok = 0.
- inst_req and data_req (write 0x12345678, wstrb 0xF, addr 0x1c008000) in the same cycle, PRIO_DATA = 1 → data granted first (mem_wr = 1), inst granted the next cycle. Two mem_data_ok pulses route to data then inst.
- mem_addr_ok held 0 for 3 cycles while data owns the grant and inst_req rises → mem_addr stays 0x1c008000 and inst_addr_ok stays 0 until the data handshake completes.
- MAX_OUTSTANDING = 2: accept 2 inst requests with no data_ok → mem_req = 0 and no addr_ok while full. One mem_data_ok frees a slot and the next request is accepted the following cycle.
- Push and pop in the same cycle for 10 back-to-back cycles → count constant, pointers wrap, IDs returned in order.
- Reset asserted while in GNT_D with 1 outstanding → next cycle state IDLE, queue empty, all outputs 0. A stray mem_data_ok then produces no *_data_ok and sets err_underflow.
